// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: op codes, op type, default width and FSM states.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned OP_W      = 3;

    typedef logic [OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_XOR = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational shared ALU: logic ops, add/sub with carry/borrow, pass-through default, zero flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] data,
    output logic             carry,
    output logic             zero
);

    // Carry lives in the extra top bit; logic ops leave it 0.
    logic [WIDTH:0] wide;

    always_comb begin
        wide = {1'b0, a};
        case (op)
            ALU_AND: wide = {1'b0, a & b};
            ALU_OR:  wide = {1'b0, a | b};
            ALU_ADD: wide = {1'b0, a} + {1'b0, b};
            ALU_SUB: wide = {1'b0, a} - {1'b0, b};
            ALU_XOR: wide = {1'b0, a ^ b};
            default: wide = {1'b0, a};
        endcase
    end

    assign data  = wide[WIDTH-1:0];
    assign carry = wide[WIDTH];
    assign zero  = (wide[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU with a one-entry response buffer.
// Define ALU_ARB_LOCK_EN to add the req_lock port and grant-hold locking.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  alu_op_t          req_op0,
    input  alu_op_t          req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
`ifdef ALU_ARB_LOCK_EN
    input  logic [1:0]       req_lock,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic             last_grant;
    logic             grant;
    logic             grant_ok;
    logic             slot_free;
    logic             xfer;
    alu_op_t          op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] alu_data;
    logic             alu_carry;
    logic             alu_zero;

`ifdef ALU_ARB_LOCK_EN
    logic lock_held;
    logic lock_id;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Grant selection, handshake and buffer occupancy.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_ok   = 1'b0;
        req_ready  = 2'b00;
        slot_free  = (state == ST_EMPTY) || rsp_ready;

        case (req_valid)
            2'b01: begin grant = 1'b0;        grant_ok = 1'b1; end
            2'b10: begin grant = 1'b1;        grant_ok = 1'b1; end
            2'b11: begin grant = ~last_grant; grant_ok = 1'b1; end
            default: begin grant = 1'b0;      grant_ok = 1'b0; end
        endcase

`ifdef ALU_ARB_LOCK_EN
        if (lock_held) begin
            grant    = lock_id;
            grant_ok = lock_id ? req_valid[1] : req_valid[0];
        end
`endif

        xfer = grant_ok && slot_free;
        if (xfer) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end

        case (state)
            ST_EMPTY: if (xfer) state_next = ST_FULL;
            ST_FULL:  if (!xfer && rsp_ready) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    assign op_sel = grant ? req_op1 : req_op0;
    assign a_sel  = grant ? req_a1  : req_a0;
    assign b_sel  = grant ? req_b1  : req_b0;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op    (op_sel),
        .a     (a_sel),
        .b     (b_sel),
        .data  (alu_data),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    // Response buffer payload; held while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            rsp_id     <= grant;
            rsp_data   <= alu_data;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
            last_grant <= grant;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // While held, the grant is pinned to lock_id, so any transfer comes from the owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_held <= 1'b0;
            lock_id   <= 1'b0;
        end else if (xfer) begin
            lock_held <= grant ? req_lock[1] : req_lock[0];
            lock_id   <= grant;
        end
    end
`endif

    assign rsp_valid = (state == ST_FULL);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter that shares one 32-bit ALU between the pipeline EX stage (requester 0) and the branch/address unit (requester 1). It accepts one operation per cycle over a valid/ready handshake, applies round-robin priority, evaluates the operation on the shared ALU, and returns a registered, tagged result with carry and zero flags through a one-entry response buffer with backpressure.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept, only the granted bit can be high
- req_op0, req_op1  in  3 each  ALU op code per requester
- req_a0, req_a1, req_b0, req_b1  in  WIDTH each  operands per requester
- req_lock  in  2  grant-hold request, present only with ALU_ARB_LOCK_EN
- rsp_valid  out  1  response buffer full
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the response
- rsp_data  out  WIDTH  result
- rsp_carry  out  1  carry/borrow flag
- rsp_zero  out  1  rsp_data == 0

## Operation
- Op codes: AND 000, OR 001, ADD 010, SUB 110, XOR 111; any other code passes a through, carry 0.
- ADD: {carry,data} = a + b, computed at WIDTH+1 bits. SUB: {carry,data} = a - b at WIDTH+1 bits, so carry = 1 exactly when a < b unsigned. Logic ops: carry 0.
- Zero is computed for every op, not only SUB.
- slot_free = !rsp_valid || rsp_ready.
- Grant: if exactly one req_valid bit is set, that requester is granted. If both are set, the requester other than last_grant is granted. req_ready[g] = slot_free; the other bit is 0.
- A transfer occurs when req_valid[g] && req_ready[g]. On a transfer, the result is loaded into the response buffer, rsp_valid is set, rsp_id = g, and last_grant = g.
- Without a transfer, rsp_ready && rsp_valid clears rsp_valid. A buffer held under rsp_valid && !rsp_ready keeps all rsp_* outputs stable.
- States: EMPTY (rsp_valid = 0) and FULL (rsp_valid = 1).
  - EMPTY to FULL on a transfer.
  - FULL stays FULL on drain plus simultaneous transfer, which gives back-to-back throughput.
  - FULL to EMPTY on drain with no transfer.
  - FULL stays FULL with no drain; req_ready is 0 in that case.
- Requests are not latched internally. Requesters hold op and operands stable while valid && !ready.

## Timing
- Latency: a transfer in cycle N gives the response visible in cycle N+1.
- Throughput: 1 op/cycle while rsp_ready stays high.
- req_ready depends combinationally on req_valid, rsp_valid, rsp_ready, and state. There is no combinational path from operands to req_ready.
- Reset (asynchronous assert, synchronous-safe deassert): rsp_valid 0, rsp_id 0, rsp_data 0, rsp_carry 0, rsp_zero 0, last_grant 1 (requester 0 wins the first tie), lock_owner cleared. Reset mid-operation discards the buffered response.

## Configuration
- ALU_ARB_LOCK_EN defined:
  - The req_lock port exists.
  - A transfer with req_lock[g] = 1 sets lock_owner = g.
  - While the lock is held, only g can be granted, even if the other requester is waiting.
  - The lock releases on a transfer from g with req_lock[g] = 0, or on reset.
- ALU_ARB_LOCK_EN undefined: the req_lock port is absent and arbitration is pure round-robin.

## Structure
- Shared package alu_pkg holds:
  - op code constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR
  - a 3-bit alu_op_t typedef
  - the WIDTH default
- Sub-module alu_core: combinational, op/a/b in, data/carry/zero out, using the rules above. It is instantiated once, fed by the grant mux.

## Test plan
- Single request: after reset, req_valid = 01, op ADD, a = 0xFFFFFFFF, b = 1 → next cycle rsp_valid 1, rsp_id 0, rsp_data 0, rsp_carry 1, rsp_zero 1.
- Tie and round-robin: both valid every cycle, rsp_ready = 1 → grants alternate 0,1,0,1. SUB 5-7 on requester 1 → rsp_data 0xFFFFFFFE, carry 1.
- Backpressure: rsp_ready = 0 for 3 cycles with both valid → req_ready = 00 and rsp_* stable. Raising rsp_ready gives a drain and a new transfer in the same cycle.
- Logic and default ops: AND 0xF0F0 & 0x0FF0 → 0x00F0, zero 0. XOR equal operands → 0, zero 1. Op 011 with a = 0x1234 → 0x1234, carry 0.
- Reset mid-operation: assert reset while FULL → rsp_valid drops immediately. After release, a tie grants requester 0.
- Lock (ALU_ARB_LOCK_EN): requester 1 issues 3 locked ops while requester 0 is valid → requester 0 is starved. Unlocking the final op gives requester 0 the grant on the next cycle.
